// File: rtl/comb_vec_checker.sv
// Sweeps every input vector onto the shared bus of several implementations of the
// same combinational function and counts the vectors where their outputs disagree.
module comb_vec_checker #(
    parameter int unsigned VEC_W  = 4,
    parameter int unsigned N_IMPL = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_IMPL-1:0] y,
    output logic [VEC_W-1:0]  vec,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [VEC_W:0]    err_cnt,
    output logic              first_err_vld,
    output logic [VEC_W-1:0]  first_err_vec,
    output logic [N_IMPL-1:0] first_err_y
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StCheck,
        StDone
    } state_e;

    localparam logic [3:0]       SettleLast = 4'(SETTLE - 1);
    localparam logic [VEC_W-1:0] VecLast    = {VEC_W{1'b1}};
    localparam logic [VEC_W:0]   ErrMax     = {1'b1, {VEC_W{1'b0}}};

    state_e              state_q, state_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [VEC_W:0]      err_cnt_q, err_cnt_d;
    logic                first_err_vld_q, first_err_vld_d;
    logic [VEC_W-1:0]    first_err_vec_q, first_err_vec_d;
    logic [N_IMPL-1:0]   first_err_y_q, first_err_y_d;
    logic                mismatch;

    // Implementations agree only when every output bit is identical.
    assign mismatch = (y != '0) && (y != '1);

    always_comb begin
        state_d         = state_q;
        vec_d           = vec_q;
        cnt_d           = cnt_q;
        err_cnt_d       = err_cnt_q;
        first_err_vld_d = first_err_vld_q;
        first_err_vec_d = first_err_vec_q;
        first_err_y_d   = first_err_y_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d         = StWait;
                    vec_d           = '0;
                    cnt_d           = '0;
                    err_cnt_d       = '0;
                    first_err_vld_d = 1'b0;
                    first_err_vec_d = '0;
                    first_err_y_d   = '0;
                end
            end
            StWait: begin
                if (cnt_q == SettleLast) begin
                    state_d = StCheck;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    if (err_cnt_q != ErrMax) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (!first_err_vld_q) begin
                        first_err_vld_d = 1'b1;
                        first_err_vec_d = vec_q;
                        first_err_y_d   = y;
                    end
                end
                if (vec_q == VecLast) begin
                    state_d = StDone;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    state_d = StWait;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            vec_q           <= '0;
            cnt_q           <= '0;
            err_cnt_q       <= '0;
            first_err_vld_q <= 1'b0;
            first_err_vec_q <= '0;
            first_err_y_q   <= '0;
        end else begin
            state_q         <= state_d;
            vec_q           <= vec_d;
            cnt_q           <= cnt_d;
            err_cnt_q       <= err_cnt_d;
            first_err_vld_q <= first_err_vld_d;
            first_err_vec_q <= first_err_vec_d;
            first_err_y_q   <= first_err_y_d;
        end
    end

    assign vec           = vec_q;
    assign busy          = (state_q == StWait) || (state_q == StCheck);
    assign done          = (state_q == StDone);
    assign pass          = done && (err_cnt_q == '0);
    assign err_cnt       = err_cnt_q;
    assign first_err_vld = first_err_vld_q;
    assign first_err_vec = first_err_vec_q;
    assign first_err_y   = first_err_y_q;

endmodule
